// File: rtl/decode_pkg.sv
// Shared constants for the decode stage: immediate-mode encodings and
// instruction field bit positions.
package decode_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_RSVD  = 2'd3
  } imm_mode_e;

  localparam int RS_LSB      = 21;
  localparam int RT_LSB      = 16;
  localparam int IMM_LSB     = 0;
  localparam int IMM_W       = 16;
  localparam int FIELD_W     = 5;
  localparam int UPPER_SHIFT = 16;

endpackage

// File: rtl/regfile.sv
// Register array with two asynchronous read ports and one synchronous write
// port; register 0 is hardwired to zero.
module regfile
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem_r [NREG];

  // register array: cleared by reset, writes to address 0 dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (we && (wa != {AW{1'b0}})) begin
      mem_r[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[ra1];
  assign rd2 = (ra2 == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[ra2];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field extraction, operand read with write bypass, immediate
// extension and a one-entry valid/ready pipeline register.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins,
  input  logic [1:0]      imm_mode,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic [XLEN-1:0] imm,
  output logic [AW-1:0]   rs_q,
  output logic [AW-1:0]   rt_q
);

  // extension is done at least 32 bits wide so the upper mode keeps its shape
  localparam int EW = (XLEN > 32) ? XLEN : 32;

  logic [AW-1:0]    rs_s;
  logic [AW-1:0]    rt_s;
  logic [IMM_W-1:0] imm16_s;
  logic [XLEN-1:0]  rf_rd1_s;
  logic [XLEN-1:0]  rf_rd2_s;
  logic [EW-1:0]    ext_s;
  logic [XLEN-1:0]  imm_s;
  logic             wr_nz_s;
  logic             take_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             ref1_s;
  logic             ref2_s;

  logic             out_valid_r;
  logic [XLEN-1:0]  rd1_r;
  logic [XLEN-1:0]  rd2_r;
  logic [XLEN-1:0]  imm_r;
  logic [AW-1:0]    rs_q_r;
  logic [AW-1:0]    rt_q_r;

  assign rs_s    = ins[RS_LSB +: AW];
  assign rt_s    = ins[RT_LSB +: AW];
  assign imm16_s = ins[IMM_LSB +: IMM_W];

  regfile #(
    .XLEN(XLEN),
    .NREG(NREG)
  ) u_regfile (
    .clk(clk),
    .rst(rst),
    .ra1(rs_s),
    .ra2(rt_s),
    .rd1(rf_rd1_s),
    .rd2(rf_rd2_s),
    .we (wr_en),
    .wa (wr_addr),
    .wd (wr_data)
  );

  // immediate extension; the reserved mode behaves as sign-extend
  always_comb begin
    ext_s = {EW{1'b0}};
    case (imm_mode_e'(imm_mode))
      IMM_ZEXT:  ext_s = {{(EW-IMM_W){1'b0}}, imm16_s};
      IMM_UPPER: ext_s = {{(EW-IMM_W){1'b0}}, imm16_s} << UPPER_SHIFT;
      default:   ext_s = {{(EW-IMM_W){imm16_s[IMM_W-1]}}, imm16_s};
    endcase
  end

  assign imm_s    = ext_s[XLEN-1:0];
  assign in_ready = !out_valid_r || out_ready;
  assign take_s   = in_valid && in_ready;
  assign wr_nz_s  = wr_en && (wr_addr != {AW{1'b0}});
  assign byp1_s   = wr_nz_s && (wr_addr == rs_s);
  assign byp2_s   = wr_nz_s && (wr_addr == rt_s);
  assign ref1_s   = out_valid_r && wr_nz_s && (wr_addr == rs_q_r);
  assign ref2_s   = out_valid_r && wr_nz_s && (wr_addr == rt_q_r);

  // pipeline register: capture on transfer, drain on accept, refresh while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      rd1_r       <= {XLEN{1'b0}};
      rd2_r       <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      rs_q_r      <= {AW{1'b0}};
      rt_q_r      <= {AW{1'b0}};
    end else if (take_s) begin
      out_valid_r <= 1'b1;
      rd1_r       <= byp1_s ? wr_data : rf_rd1_s;
      rd2_r       <= byp2_s ? wr_data : rf_rd2_s;
      imm_r       <= imm_s;
      rs_q_r      <= rs_s;
      rt_q_r      <= rt_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      if (ref1_s) begin
        rd1_r <= wr_data;
      end
      if (ref2_s) begin
        rd2_r <= wr_data;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign rd1       = rd1_r;
  assign rd2       = rd2_r;
  assign imm       = imm_r;
  assign rs_q      = rs_q_r;
  assign rt_q      = rt_q_r;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ins;
  logic [1:0]  imm_mode;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_rd1, m_rd2, m_imm;
  logic [4:0]  m_rs, m_rt;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .imm_mode(imm_mode), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .rd1(rd1), .rd2(rd2), .imm(imm), .rs_q(rs_q), .rt_q(rt_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] v);
    return {6'd0, rs, rt, v};
  endfunction

  function automatic logic [31:0] ext_model(input logic [15:0] v, input logic [1:0] m);
    if (m == 2'd1) return 32'(v);
    if (m == 2'd2) return 32'(v) * 32'd65536;
    return (v >= 16'h8000) ? (32'(v) + 32'hFFFF_0000) : 32'(v);
  endfunction

  // operand value as seen by a capture this cycle (a same-cycle write wins)
  function automatic logic [31:0] read_model(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    m_rd1 = 32'd0; m_rd2 = 32'd0; m_imm = 32'd0;
    m_rs = 5'd0; m_rt = 5'd0;
  endtask

  // one clock: check in_ready, advance the model, then check the outputs
  task automatic step();
    logic rdy;
    #1;
    rdy = !m_valid || out_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (rst) begin
      model_reset();
    end else begin
      if (in_valid && rdy) begin
        m_valid = 1'b1;
        m_rs = ins[25:21];
        m_rt = ins[20:16];
        m_rd1 = read_model(ins[25:21]);
        m_rd2 = read_model(ins[20:16]);
        m_imm = ext_model(ins[15:0], imm_mode);
      end else if (out_ready) begin
        m_valid = 1'b0;
      end else if (m_valid && wr_en && wr_addr != 5'd0) begin
        if (wr_addr == m_rs) m_rd1 = wr_data;
        if (wr_addr == m_rt) m_rd2 = wr_data;
      end
      if (wr_en && wr_addr != 5'd0) m_regs[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid || rst) begin
      check("rd1", rd1, m_rd1);
      check("rd2", rd2, m_rd2);
      check("imm", imm, m_imm);
      check("rs_q", {27'd0, rs_q}, {27'd0, m_rs});
      check("rt_q", {27'd0, rt_q}, {27'd0, m_rt});
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; ins = 32'd0; imm_mode = 2'd0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_5555; out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_rd1", rd1, 32'd0);
    check("reset_imm", imm, 32'd0);
    step();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // reset then read: rs=1, rt=2, plus register 3 written only during reset
    in_valid = 1'b1; ins = 32'h0022_0000;
    step();
    check("rst_read_valid", {31'd0, out_valid}, 32'd1);
    check("rst_read_rd1", rd1, 32'd0);
    check("rst_read_rd2", rd2, 32'd0);
    ins = mk(5'd3, 5'd0, 16'd0);
    step();
    check("write_during_reset_ignored", rd1, 32'd0);

    // bypass on same-cycle write, then register-file value, then register 0
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; ins = mk(5'd5, 5'd0, 16'd0);
    step();
    check("bypass_rd1", rd1, 32'hDEAD_BEEF);
    wr_en = 1'b0;
    step();
    check("rf_rd1", rd1, 32'hDEAD_BEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234_5678; ins = mk(5'd0, 5'd0, 16'd0);
    step();
    check("r0_bypass_blocked", rd1, 32'd0);
    wr_en = 1'b0;
    step();
    check("r0_reads_zero", rd1, 32'd0);

    // immediate modes on 0x8001
    ins = mk(5'd0, 5'd0, 16'h8001);
    imm_mode = 2'd0; step(); check("imm_sext", imm, 32'hFFFF_8001);
    imm_mode = 2'd1; step(); check("imm_zext", imm, 32'h0000_8001);
    imm_mode = 2'd2; step(); check("imm_upper", imm, 32'h8001_0000);
    imm_mode = 2'd3; step(); check("imm_rsvd", imm, 32'hFFFF_8001);

    // stall: hold A for 3 cycles with B waiting, refresh rd2 via write to rt_q
    in_valid = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
    step();
    wr_en = 1'b0; in_valid = 1'b1; imm_mode = 2'd1; ins = mk(5'd5, 5'd7, 16'h1234);
    step();
    check("stall_a_rd2", rd2, 32'h1111_1111);
    out_ready = 1'b0; ins = mk(5'd7, 5'd5, 16'h00FF);
    for (int c = 0; c < 3; c++) begin
      wr_en = (c == 1); wr_addr = 5'd7; wr_data = 32'h2222_2222;
      step();
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_rd1_held", rd1, 32'hDEAD_BEEF);
      check("stall_imm_held", imm, 32'h0000_1234);
      check("stall_rs_q_held", {27'd0, rs_q}, 32'd5);
      check("stall_rd2", rd2, (c == 0) ? 32'h1111_1111 : 32'h2222_2222);
    end
    wr_en = 1'b0; out_ready = 1'b1;
    step();
    check("release_rs_q", {27'd0, rs_q}, 32'd7);
    check("release_rd1", rd1, 32'h2222_2222);
    check("release_rd2", rd2, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    step();
    check("release_no_dup", {31'd0, out_valid}, 32'd0);

    // throughput: 8 back-to-back instructions
    in_valid = 1'b1; imm_mode = 2'd1;
    for (int i = 0; i < 8; i++) begin
      ins = mk(5'(i + 8), 5'd0, 16'(i));
      step();
      check("tput_valid", {31'd0, out_valid}, 32'd1);
      check("tput_order", {27'd0, rs_q}, 32'(i + 8));
      check("tput_imm", imm, 32'(i));
    end
    in_valid = 1'b0;
    step();
    check("tput_drain", {31'd0, out_valid}, 32'd0);

    // random traffic against the model
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ins       = $urandom;
      imm_mode  = 2'($urandom_range(0, 3));
      wr_en     = ($urandom_range(0, 1) == 1);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom;
      if ($urandom_range(0, 2) == 0) wr_addr = ins[25:21];
      else if ($urandom_range(0, 2) == 0) wr_addr = rs_q;
      step();
    end

    // mid-stream reset
    wr_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1; ins = mk(5'd1, 5'd2, 16'h7777);
    step();
    out_ready = 1'b0;
    step();
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF;
    step();
    check("midreset_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_rd1", rd1, 32'd0);
    check("midreset_imm", imm, 32'd0);
    rst = 1'b0; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("midreset_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1;
    for (int r = 0; r < 16; r++) begin
      ins = mk(5'(2 * r), 5'(2 * r + 1), 16'd0);
      step();
      check("cleared_rd1", rd1, 32'd0);
      check("cleared_rd2", rd2, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
